// File: rtl/team_06_echo_pkg.sv
// -----------------------------------------------------------------------------
// team_06_echo_pkg
// Shared definitions for the echo history buffer slice:
//   - state_e    : history-buffer controller states (IDLE, WRITE, READ, RESP)
//   - DEPTH_DEF  : default number of history samples (power of two)
//   - ADDR_W_DEF : default memory address width, log2(DEPTH_DEF)
//   - SAMPLE_W   : audio sample width
// -----------------------------------------------------------------------------
package team_06_echo_pkg;

  localparam int unsigned DEPTH_DEF  = 32'd8192;
  localparam int unsigned ADDR_W_DEF = 32'd13;
  localparam int unsigned SAMPLE_W   = 32'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/team_06_echo_hist_ptr.sv
// -----------------------------------------------------------------------------
// team_06_echo_hist_ptr
// Pointer bookkeeping for the circular history buffer.
//   clk, rst   : clock, asynchronous active-low reset
//   wr_adv     : one-cycle strobe, a sample has been committed to memory
//   rd_off     : requested age of the sample (0 = most recent)
//   wr_ptr     : address the next sample will be written to (wraps at DEPTH)
//   rd_addr    : address holding the sample rd_off samples ago
//   guard_hit  : requested age lies beyond the recorded history
// Build option TEAM_06_ECHO_FILL_GUARD_EN: when defined a saturating fill
// counter is kept and guard_hit reports reads of unwritten history; when
// undefined there is no fill counter and guard_hit is tied low.
// -----------------------------------------------------------------------------
module team_06_echo_hist_ptr
  import team_06_echo_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_adv,
  input  logic [ADDR_W-1:0] rd_off,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              guard_hit
);

  logic [ADDR_W-1:0] wr_ptr_r;

  // Write pointer: DEPTH is a power of two, so natural overflow wraps DEPTH-1 to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
    end else if (wr_adv) begin
      wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
    end
  end

  assign wr_ptr  = wr_ptr_r;
  // wr_ptr points one past the newest sample, hence the extra -1.
  assign rd_addr = wr_ptr_r - ADDR_W'(1) - rd_off;

`ifdef TEAM_06_ECHO_FILL_GUARD_EN
  localparam logic [ADDR_W:0] FILL_MAX = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W:0] fill_r;

  // Fill counter: counts committed samples, saturating once the buffer is full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_r <= '0;
    end else if (wr_adv && (fill_r != FILL_MAX)) begin
      fill_r <= fill_r + (ADDR_W+1)'(1);
    end
  end

  // Once full, every representable offset (max DEPTH-1) is below fill.
  assign guard_hit = ({1'b0, rd_off} >= fill_r);
`else
  assign guard_hit = 1'b0;
`endif

endmodule

// File: rtl/team_06_echo_history_buffer.sv
// -----------------------------------------------------------------------------
// team_06_echo_history_buffer
// Records every finished echo output sample into a circular buffer kept in an
// external single-port memory and answers "sample from offset ago" requests.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   save_audio, save_valid   : sample to record and its one-cycle strobe
//   search, offset           : one-cycle history request and requested age
//   past_output              : returned sample, held until the next response
//   search_enable            : one-cycle pulse marking past_output valid
//   overflow                 : sticky, a sample arrived while one was pending
//   mem_req/we/addr/wdata    : memory request, held until mem_ack
//   mem_rdata, mem_ack       : memory read data and completion strobe
// Build option TEAM_06_ECHO_FILL_GUARD_EN: when defined, requests older than
// the recorded history return 0 without touching memory; when undefined every
// request reads memory and returns its raw contents.
// -----------------------------------------------------------------------------
module team_06_echo_history_buffer
  import team_06_echo_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] save_audio,
  input  logic                save_valid,
  input  logic                search,
  input  logic [ADDR_W-1:0]   offset,
  output logic [SAMPLE_W-1:0] past_output,
  output logic                search_enable,
  output logic                overflow,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [SAMPLE_W-1:0] mem_wdata,
  input  logic [SAMPLE_W-1:0] mem_rdata,
  input  logic                mem_ack
);

  state_e              state_r;
  state_e              state_nxt_s;

  logic                ps_valid_r;
  logic [SAMPLE_W-1:0] ps_data_r;
  logic                pr_valid_r;
  logic [ADDR_W-1:0]   pr_off_r;
  logic                overflow_r;

  logic                ps_clr_s;
  logic                pr_clr_s;
  logic                wr_adv_s;
  logic                guard_enter_s;
  logic                resp_guard_r;

  logic [ADDR_W-1:0]   wr_ptr_s;
  logic [ADDR_W-1:0]   rd_addr_s;
  logic                guard_hit_s;

  logic [SAMPLE_W-1:0] past_output_r;
  logic                search_enable_r;
  logic                mem_req_r;
  logic                mem_we_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [SAMPLE_W-1:0] mem_wdata_r;

  team_06_echo_hist_ptr #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .wr_adv    (wr_adv_s),
    .rd_off    (pr_off_r),
    .wr_ptr    (wr_ptr_s),
    .rd_addr   (rd_addr_s),
    .guard_hit (guard_hit_s)
  );

  // Pending-sample slot: one deep; a sample arriving while it is occupied is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_valid_r <= 1'b0;
      ps_data_r  <= '0;
      overflow_r <= 1'b0;
    end else if (ps_valid_r) begin
      if (ps_clr_s) begin
        ps_valid_r <= 1'b0;
      end
      if (save_valid) begin
        overflow_r <= 1'b1;
      end
    end else if (save_valid) begin
      ps_valid_r <= 1'b1;
      ps_data_r  <= save_audio;
    end
  end

  // Pending-search slot: one deep; a search while one is outstanding is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pr_valid_r <= 1'b0;
      pr_off_r   <= '0;
    end else if (pr_valid_r) begin
      if (pr_clr_s) begin
        pr_valid_r <= 1'b0;
      end
    end else if (search) begin
      pr_valid_r <= 1'b1;
      pr_off_r   <= offset;
    end
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and slot/pointer control strobes.
  always_comb begin
    state_nxt_s   = state_r;
    ps_clr_s      = 1'b0;
    pr_clr_s      = 1'b0;
    wr_adv_s      = 1'b0;
    guard_enter_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ps_valid_r) begin
          state_nxt_s = ST_WRITE;
        end else if (pr_valid_r) begin
          if (guard_hit_s) begin
            state_nxt_s   = ST_RESP;
            guard_enter_s = 1'b1;
          end else begin
            state_nxt_s = ST_READ;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          wr_adv_s    = 1'b1;
          ps_clr_s    = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_READ: begin
        if (mem_ack) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      ST_RESP: begin
        pr_clr_s    = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Remembers that the current RESP visit came from the fill guard (no read data).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_guard_r <= 1'b0;
    end else if (guard_enter_s) begin
      resp_guard_r <= 1'b1;
    end else if (state_r == ST_RESP) begin
      resp_guard_r <= 1'b0;
    end
  end

  // Memory request registers: loaded on entry to WRITE/READ, held until ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else begin
      mem_req_r <= (state_nxt_s == ST_WRITE) || (state_nxt_s == ST_READ);
      mem_we_r  <= (state_nxt_s == ST_WRITE);
      if ((state_r == ST_IDLE) && (state_nxt_s == ST_WRITE)) begin
        mem_addr_r  <= wr_ptr_s;
        mem_wdata_r <= ps_data_r;
      end else if ((state_r == ST_IDLE) && (state_nxt_s == ST_READ)) begin
        mem_addr_r  <= rd_addr_s;
      end
    end
  end

  // Response registers: read data is returned straight off the ack; a guard hit
  // answers 0 one cycle after entering RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      past_output_r   <= '0;
      search_enable_r <= 1'b0;
    end else if ((state_r == ST_READ) && mem_ack) begin
      past_output_r   <= mem_rdata;
      search_enable_r <= 1'b1;
    end else if ((state_r == ST_RESP) && resp_guard_r) begin
      past_output_r   <= '0;
      search_enable_r <= 1'b1;
    end else begin
      search_enable_r <= 1'b0;
    end
  end

  assign past_output   = past_output_r;
  assign search_enable = search_enable_r;
  assign overflow      = overflow_r;
  assign mem_req       = mem_req_r;
  assign mem_we        = mem_we_r;
  assign mem_addr      = mem_addr_r;
  assign mem_wdata     = mem_wdata_r;

endmodule

// File: tb/tb_team_06_echo_history_buffer.sv
// -----------------------------------------------------------------------------
// tb_team_06_echo_history_buffer
// Self-checking bench: a behavioural memory with programmable ack delay and a
// reference model holding the list of recorded samples; expected responses are
// looked up from that list by age.
// -----------------------------------------------------------------------------
module tb_team_06_echo_history_buffer;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        save_audio;
  logic              save_valid;
  logic              search;
  logic [ADDR_W-1:0] offset;
  logic [7:0]        past_output;
  logic              search_enable;
  logic              overflow;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;
  logic              mem_ack_m;
  logic              extra_ack;

  always #5 clk = ~clk;

  team_06_echo_history_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .save_audio(save_audio), .save_valid(save_valid),
    .search(search), .offset(offset), .past_output(past_output),
    .search_enable(search_enable), .overflow(overflow), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  assign mem_ack = mem_ack_m | extra_ack;

  // Behavioural memory
  logic [7:0]        mem_arr [DEPTH];
  int                ack_delay = 1;
  int                wait_cnt;
  int                n_wr = 0;
  int                n_rd = 0;
  logic [ADDR_W-1:0] last_waddr;
  logic [ADDR_W-1:0] last_raddr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_ack_m <= 1'b0;
      wait_cnt  <= 0;
    end else if (mem_ack_m) begin
      mem_ack_m <= 1'b0;
      wait_cnt  <= 0;
    end else if (mem_req) begin
      if (wait_cnt + 1 >= ack_delay) begin
        mem_ack_m <= 1'b1;
        if (mem_we) begin
          mem_arr[mem_addr] <= mem_wdata;
          last_waddr        <= mem_addr;
          n_wr              <= n_wr + 1;
        end else begin
          mem_rdata  <= mem_arr[mem_addr];
          last_raddr <= mem_addr;
          n_rd       <= n_rd + 1;
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  int se_count  = 0;
  int req_count = 0;
  always @(negedge clk) begin
    if (search_enable) se_count++;
    if (mem_req) req_count++;
  end

  // Reference model: every recorded sample, oldest first.
  logic [7:0] hist[$];
  int n_cmp = 0;
  int n_bad = 0;
`ifdef TEAM_06_ECHO_FILL_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int avail();
    return (hist.size() < DEPTH) ? hist.size() : DEPTH;
  endfunction

  function automatic logic [7:0] ref_val(input int off);
    if (off < avail()) return hist[hist.size() - 1 - off];
    return 8'd0;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    save_valid = 1'b0; search = 1'b0; save_audio = 8'd0; offset = '0; extra_ack = 1'b0;
    tick(); tick();
    rst = 1'b1;
    hist.delete();
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_past"}, past_output, 0);
    chk({tag, "_se"}, search_enable, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
  endtask

  // Record one sample and wait until its write completes and the slot frees.
  task automatic do_save(input string tag, input logic [7:0] v);
    int w0 = n_wr;
    bit done = 1'b0;
    save_valid = 1'b1; save_audio = v;
    tick();
    save_valid = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (n_wr != w0) begin done = 1'b1; break; end
      tick();
    end
    if (!done) chk({tag, "_wr_timeout"}, 0, 1);
    tick();
    hist.push_back(v);
  endtask

  // Issue a search (optionally with a sample in the same cycle) and check the
  // returned value; exp_lat < 0 skips the latency check.
  task automatic do_search(input string tag, input bit with_save, input logic [7:0] v,
                           input int off, input int exp_lat, output bit first_we);
    int lat = -1;
    bit seen_req = 1'b0;
    logic [7:0] exp;
    first_we = 1'b0;
    if (with_save) hist.push_back(v);
    exp = ref_val(off);
    save_valid = with_save; save_audio = v;
    search = 1'b1; offset = off[ADDR_W-1:0];
    tick();
    save_valid = 1'b0; search = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      tick();
      if (mem_req && !seen_req) begin seen_req = 1'b1; first_we = mem_we; end
      if (search_enable) begin lat = c; break; end
    end
    if (lat < 0) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      chk({tag, "_val"}, past_output, exp);
      if (exp_lat >= 0) chk({tag, "_lat"}, lat, exp_lat);
      tick();
      chk({tag, "_pulse"}, search_enable, 0);
      chk({tag, "_hold"}, past_output, exp);
    end
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit fw;
    int s0, r0, w0, hi, off, kind;
    bit done;

    // Reset state
    do_reset();
    check_idle_outputs("reset");

    // Basic record and recall
    ack_delay = 1;
    do_save("w10", 8'd10);
    do_save("w20", 8'd20);
    do_save("w30", 8'd30);
    s0 = se_count;
    do_search("off0", 1'b0, 8'd0, 0, 3, fw);
    do_search("off1", 1'b0, 8'd0, 1, 3, fw);
    do_search("off2", 1'b0, 8'd0, 2, 3, fw);
    chk("basic_pulses", se_count - s0, 3);

    // Fill guard: reading beyond recorded history
    if (GUARD) begin
      do_reset();
      do_save("g1", 8'd11);
      do_save("g2", 8'd12);
      r0 = req_count;
      do_search("guard", 1'b0, 8'd0, 5, 2, fw);
      chk("guard_noreq", req_count - r0, 0);
    end

    // Same-cycle sample and search: write goes first
    do_reset();
    do_search("same", 1'b1, 8'd77, 0, -1, fw);
    chk("same_write_first", fw, 1);
    chk("same_nwr", last_waddr, 0);

    // Overflow: second sample arrives while the first is still pending
    do_reset();
    ack_delay = 5;
    w0 = n_wr;
    save_valid = 1'b1; save_audio = 8'd55; tick();
    save_valid = 1'b0; tick();
    save_valid = 1'b1; save_audio = 8'd66; tick();
    save_valid = 1'b0;
    hist.push_back(8'd55);
    for (int c = 0; c < 20; c++) tick();
    chk("ovf_set", overflow, 1);
    chk("ovf_one_write", n_wr - w0, 1);
    ack_delay = 1;
    do_search("ovf_read", 1'b0, 8'd0, 0, 3, fw);
    chk("ovf_sticky", overflow, 1);
    do_reset();
    chk("ovf_cleared", overflow, 0);

    // Wrap-around and saturation
    for (int i = 0; i < DEPTH + 2; i++) do_save("wrap_w", 8'(i % 256));
    chk("wrap_waddr", last_waddr, 1);
    do_search("wrap_off0", 1'b0, 8'd0, 0, 3, fw);
    chk("wrap_val_const", past_output, (DEPTH + 1) % 256);
    chk("wrap_raddr", last_raddr, 1);
    do_search("wrap_oldest", 1'b0, 8'd0, DEPTH - 1, 3, fw);
`ifdef TEAM_06_ECHO_FILL_GUARD_EN
    chk("fill_sat", dut.u_ptr.fill_r, DEPTH);
`endif

    // Reset while a read is in flight; a stray ack afterwards is ignored
    ack_delay = 20;
    search = 1'b1; offset = '0; tick();
    search = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (mem_req && !mem_we) begin done = 1'b1; break; end
      tick();
    end
    chk("rst_mid_inread", done, 1);
    #2 rst = 1'b0;
    #1 check_idle_outputs("rst_mid");
    tick();
    rst = 1'b1;
    hist.delete();
    s0 = se_count;
    extra_ack = 1'b1; tick();
    extra_ack = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    chk("rst_late_ack", se_count - s0, 0);
    chk("rst_late_req", mem_req, 0);
    ack_delay = 1;

    // Randomized traffic against the reference model
    for (int it = 0; it < 150; it++) begin
      ack_delay = $urandom_range(1, 3);
      kind = $urandom_range(0, 2);
      if (kind == 1 && !GUARD && avail() == 0) kind = 0;
      if (kind == 0) begin
        do_save("rnd_w", 8'($urandom_range(0, 255)));
      end else if (kind == 1) begin
        if (GUARD) begin
          hi = avail() + 3;
          if (hi > DEPTH - 1) hi = DEPTH - 1;
        end else begin
          hi = avail() - 1;
        end
        off = $urandom_range(0, hi);
        do_search("rnd_r", 1'b0, 8'd0, off, -1, fw);
      end else begin
        hi = (GUARD) ? avail() + 3 : avail();
        if (hi > DEPTH - 1) hi = DEPTH - 1;
        off = $urandom_range(0, hi);
        do_search("rnd_wr", 1'b1, 8'($urandom_range(0, 255)), off, -1, fw);
        chk("rnd_wr_first", fw, 1);
      end
    end
    chk("rnd_no_ovf", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
